fir_coeff_loader: RTL
=====================

Name: fir_coeff_loader

Overview:
Upstream configuration stage for fir_interpolator. It accepts a framed coefficient stream over a valid/ready handshake and drives the interpolator's c_we/c_addr/c_in write port, one coefficient per accepted beat. It verifies a trailing checksum word, aborts frames that stall too long, and reports busy/ok/error status. While the loader drives c_we high, the interpolator holds its datapath frozen.

Parameters:
ORD, 255, filter order; the loader writes NUM_COEFF = (ORD+1)/2 coefficients (symmetric half).
COEFF_SIZE, 16, coefficient width in bits; also the stream word width and the checksum width.
TIMEOUT, 1024, maximum idle cycles between beats inside a frame before the frame is aborted; must be >= 2.
AW, $clog2((ORD+1)>>1), address width; matches fir_interpolator c_addr.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_first  in  1  marks the first coefficient of a frame; qualified by s_valid
s_data  in  COEFF_SIZE  coefficient or checksum word
c_we  out  1  coefficient write enable to the interpolator
c_addr  out  AW  coefficient address
c_in  out  COEFF_SIZE  coefficient data
busy  out  1  frame in progress
coeff_ok  out  1  last frame loaded and checksum matched
load_done  out  1  one-cycle pulse at the end of every frame (pass or fail)
load_err  out  1  sticky error; cleared at the start of the next frame

Behaviour:
- A beat is accepted when s_valid && s_ready. s_ready is 1 in every state except DONE.
- Reset (rst sampled high on a clk edge) applies these values: state=IDLE, c_we=0, c_addr=0, c_in=0, busy=0, coeff_ok=0, load_done=0, load_err=0. All counters and the checksum clear. Reset mid-frame abandons the frame immediately; no further writes are issued.
- State IDLE:
  - A beat with s_first=1 starts a frame: go to LOAD, idx=0, sum=0, clear coeff_ok and load_err, set busy.
  - That first beat is itself coefficient 0 and is written exactly as a LOAD beat.
  - Beats with s_first=0 are accepted and dropped.
- State LOAD:
  - Each accepted beat registers c_we=1, c_addr=idx, c_in=s_data on the next cycle (latency 1 clk).
  - On the same beat: sum <= sum + s_data, modulo 2^COEFF_SIZE; idx increments.
  - In every cycle with no accepted beat, c_we=0.
  - When the beat at idx=NUM_COEFF-1 is accepted, go to CHECK.
- State CHECK: the next accepted beat is the checksum.
  - If s_data == sum: set coeff_ok=1.
  - Otherwise: set load_err=1.
  - Either way, go to DONE. The checksum beat is never written to the coefficient RAM.
- State DONE (one cycle): load_done=1, busy=0, s_ready=0, then go to IDLE.
- s_first=1 on a beat in LOAD or CHECK means a resync:
  - Set load_err.
  - Restart the frame with that beat as coefficient 0 (idx=0, sum=s_data). busy stays 1.
  - No load_done pulse is issued for the aborted frame.
- Timeout:
  - In LOAD or CHECK, an idle counter counts cycles with no accepted beat and resets on each accepted beat.
  - When the counter reaches TIMEOUT: set load_err=1, go to DONE. The partial coefficients stay written.
- Simultaneous events:
  - A beat accepted in the same cycle the counter reaches TIMEOUT: the beat wins, no timeout.
  - rst overrides everything else.
- Address wrap: idx never exceeds NUM_COEFF-1, so c_addr never wraps.
- c_we is a pulse per beat. Back-to-back beats give back-to-back writes.

Decomposition:
- Shared include fir_defs.vh holds:
  - the localparam NUM_COEFF derivation, shared with fir_interpolator;
  - the state encodings IDLE=0, LOAD=1, CHECK=2, DONE=3.
- One natural sub-module, timeout_counter (parameter TIMEOUT). Inputs: clr, en. Output: expired, a sticky level until clr.

Test Plan:
- Normal load, ORD=7 (NUM_COEFF=4): beats 0x0001(first), 0x0002, 0x0003, 0x0004, then checksum 0x000A, all with s_valid held high. Required: c_we high for 4 consecutive cycles with c_addr 0..3 and c_in 1..4, each one cycle after its beat; coeff_ok=1; load_done pulses once; load_err=0.
- Bad checksum: same frame, checksum 0x000B. Required: 4 writes occur, load_err=1, coeff_ok=0, load_done pulses once.
- Checksum wrap: coefficients 0xFFFF, 0x0002, 0, 0, checksum 0x0001. Required: coeff_ok=1.
- Resync: after 2 beats, a beat 0x0007 arrives with s_first=1, followed by 3 more beats and a valid checksum. Required: that beat is written to c_addr=0; load_err=1; no load_done until the end of the restarted frame.
- Timeout, TIMEOUT=8: stop after 2 beats. Required: load_err=1 and a load_done pulse 8 cycles after the last beat; busy=0; the next s_first starts a new frame and clears load_err.
- Reset mid-frame: assert rst after beat 2. Required: next cycle all outputs are 0 and state is IDLE; beats without s_first are then dropped with no c_we.

Source files
------------

// File: rtl/fir_coeff_loader_pkg.sv
// Shared types and derived constants for the FIR coefficient loader.
// State encodings match the ones used by fir_interpolator tooling.
package fir_coeff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Symmetric filter: only the first half of the taps is stored.
    function automatic int unsigned num_coeff(input int unsigned ord);
        return (ord + 1) / 2;
    endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Framed coefficient stream: valid/ready handshake with a first-beat marker.
interface fir_coeff_loader_if #(
    parameter int unsigned DW = 16
);
    logic          s_valid;
    logic          s_ready;
    logic          s_first;
    logic [DW-1:0] s_data;

    modport master (output s_valid, output s_first, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_first, input  s_data, output s_ready);
endinterface

// File: rtl/fir_coeff_loader_timeout_counter.sv
// Idle-cycle counter; expired rises once TIMEOUT-1 idle cycles have elapsed,
// so the consumer aborts on the TIMEOUT-th idle cycle. Sticky until clr.
module fir_coeff_loader_timeout_counter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic          expired_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else if (en && !expired_q) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(TIMEOUT - 2)) begin
                expired_q <= 1'b1;
            end
        end
    end

    assign expired = expired_q;
endmodule

// File: rtl/fir_coeff_loader.sv
// Loads a framed, checksummed coefficient stream into the fir_interpolator
// coefficient port and reports busy/ok/error status.
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int unsigned ORD        = 255,
    parameter int unsigned COEFF_SIZE = 16,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned AW         = $clog2((ORD + 1) >> 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_coeff_loader_if.slave     s,
    output logic                  c_we,
    output logic [AW-1:0]         c_addr,
    output logic [COEFF_SIZE-1:0] c_in,
    output logic                  busy,
    output logic                  coeff_ok,
    output logic                  load_done,
    output logic                  load_err
);
    localparam int unsigned   NUM_COEFF = num_coeff(ORD);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_COEFF - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [COEFF_SIZE-1:0] sum_q, sum_d;
    logic                  c_we_q, c_we_d;
    logic [AW-1:0]         c_addr_q, c_addr_d;
    logic [COEFF_SIZE-1:0] c_in_q, c_in_d;
    logic                  busy_q, busy_d;
    logic                  coeff_ok_q, coeff_ok_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  ready_q, ready_d;

    logic                  beat;
    logic                  in_frame;
    logic                  tmo_expired;
    logic                  wr;
    logic [AW-1:0]         wr_idx;
    logic [COEFF_SIZE-1:0] wr_base;

    assign beat     = s.s_valid && ready_q;
    assign in_frame = (state_q == ST_LOAD) || (state_q == ST_CHECK);

    fir_coeff_loader_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (beat || !in_frame),
        .en      (in_frame && !beat),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            c_we_q      <= 1'b0;
            c_addr_q    <= '0;
            c_in_q      <= '0;
            busy_q      <= 1'b0;
            coeff_ok_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            c_we_q      <= c_we_d;
            c_addr_q    <= c_addr_d;
            c_in_q      <= c_in_d;
            busy_q      <= busy_d;
            coeff_ok_q  <= coeff_ok_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state: a beat carrying s_first always (re)starts at coefficient 0.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        c_we_d      = 1'b0;
        c_addr_d    = c_addr_q;
        c_in_d      = c_in_q;
        busy_d      = busy_q;
        coeff_ok_d  = coeff_ok_q;
        load_err_d  = load_err_q;
        load_done_d = 1'b0;
        ready_d     = 1'b1;
        wr          = 1'b0;
        wr_idx      = '0;
        wr_base     = '0;

        case (state_q)
            ST_IDLE: begin
                if (beat && s.s_first) begin
                    busy_d     = 1'b1;
                    coeff_ok_d = 1'b0;
                    load_err_d = 1'b0;
                    wr         = 1'b1;
                end
            end
            ST_LOAD, ST_CHECK: begin
                if (beat && s.s_first) begin
                    load_err_d = 1'b1;
                    wr         = 1'b1;
                end else if (beat && (state_q == ST_LOAD)) begin
                    wr      = 1'b1;
                    wr_idx  = idx_q;
                    wr_base = sum_q;
                end else if (beat) begin
                    if (s.s_data == sum_q) begin
                        coeff_ok_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    load_err_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr) begin
            c_we_d   = 1'b1;
            c_addr_d = wr_idx;
            c_in_d   = s.s_data;
            sum_d    = wr_base + s.s_data;
            if (wr_idx == LAST_IDX) begin
                idx_d   = wr_idx;
                state_d = ST_CHECK;
            end else begin
                idx_d   = wr_idx + AW'(1);
                state_d = ST_LOAD;
            end
        end

        if (state_d == ST_DONE) begin
            busy_d      = 1'b0;
            load_done_d = 1'b1;
            ready_d     = 1'b0;
        end
    end

    assign s.s_ready = ready_q;
    assign c_we      = c_we_q;
    assign c_addr    = c_addr_q;
    assign c_in      = c_in_q;
    assign busy      = busy_q;
    assign coeff_ok  = coeff_ok_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
endmodule
